// File: rtl/store_lane_unit.sv
// Store path: narrows a register value to byte lanes, builds word-aligned strobes
// and drives the data-memory write port, splitting word-crossing stores in two beats.

module store_lane_byte #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] data_i,
  output logic        strb_o,
  output logic [7:0]  byte_o
);
  int         src;
  logic [1:0] sel;

  // Lane LANE of the 64-bit shifted image takes source byte (LANE - off).
  always_comb begin
    strb_o = 1'b0;
    byte_o = 8'h00;
    sel    = 2'b00;
    src    = LANE - int'({30'b0, off_i});
    if (src >= 0 && src <= 3) begin
      sel = src[1:0];
      if (mask_i[sel]) begin
        strb_o = 1'b1;
        byte_o = data_i[{sel, 3'b000} +: 8];
      end
    end
  end
endmodule

module store_lane_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_size_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_e;

  state_e      state_q;
  logic        mem_valid_q, done_q, err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, b1_addr_q, b1_wdata_q;
  logic [3:0]  mem_wstrb_q, b1_strb_q;

  logic [3:0]                     req_mask;
  logic [NUM_LANES-1:0]           lane_strb;
  logic [NUM_LANES-1:0][7:0]      lane_byte;
  logic [31:0]                    b0_addr;
  logic                           req_cross, req_illegal;

  always_comb begin
    req_mask = 4'b0000;
    case (req_size_i)
      2'b00:   req_mask = 4'b0001;
      2'b01:   req_mask = 4'b0011;
      2'b10:   req_mask = 4'b1111;
      default: req_mask = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    store_lane_byte #(.LANE(i)) u_lane (
      .off_i  (req_addr_i[1:0]),
      .mask_i (req_mask),
      .data_i (req_data_i),
      .strb_o (lane_strb[i]),
      .byte_o (lane_byte[i])
    );
  end

  assign b0_addr     = {req_addr_i[31:2], 2'b00};
  assign req_cross   = |lane_strb[7:4];
  assign req_illegal = (req_size_i == 2'b11) || (req_cross && !SPLIT_EN);

  // Beat 1 is captured at accept so it can follow beat 0 with no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= '0;
      b1_strb_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (req_illegal) begin
              err_q <= 1'b1;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= b0_addr;
              mem_wdata_q <= lane_byte[3:0];
              mem_wstrb_q <= lane_strb[3:0];
              b1_addr_q   <= b0_addr + 32'd4;
              b1_wdata_q  <= lane_byte[7:4];
              b1_strb_q   <= lane_strb[7:4];
              state_q     <= S_BEAT0;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready_i) begin
            if (|b1_strb_q) begin
              mem_addr_q  <= b1_addr_q;
              mem_wdata_q <= b1_wdata_q;
              mem_wstrb_q <= b1_strb_q;
              state_q     <= S_BEAT1;
            end else begin
              mem_valid_q <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_BEAT1: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_store_lane_unit.sv
// Directed bench for store_lane_unit: vector table with mem_ready high, plus
// backpressure, no-split rejection and mid-split reset sequences.

module tb_store_lane_unit;
  logic        clk, rst_n;
  logic        req_valid, req_valid_ns, mem_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        req_ready_ns, mem_valid_ns, done_ns, err_ns;
  logic [31:0] mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_wstrb_ns;

  int n_total = 0;
  int n_pass  = 0;

  store_lane_unit #(.SPLIT_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .done_o(done), .err_o(err)
  );

  store_lane_unit #(.SPLIT_EN(1'b0)) dut_ns (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid_ns), .req_ready_o(req_ready_ns),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
    .mem_valid_o(mem_valid_ns), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr_ns),
    .mem_wdata_o(mem_wdata_ns), .mem_wstrb_o(mem_wstrb_ns), .done_o(done_ns), .err_o(err_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [1:0]  beats;   // 0 = rejected with err
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    chk({tag, "_valid"}, mem_valid, 1);
    chk({tag, "_addr"},  mem_addr,  a);
    chk({tag, "_strb"},  mem_wstrb, s);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_done"},  done,      0);
    chk({tag, "_err"},   err,       0);
  endtask

  task automatic chk_idle_done(input string tag);
    chk({tag, "_done"},  done,      1);
    chk({tag, "_err"},   err,       0);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  // Apply one request with mem_ready held high and check each cycle up to done/err.
  task automatic do_store(input vec_t v, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
    tick();
    req_valid = 1'b0;
    if (v.beats == 2'd0) begin
      chk({tag, "_err"},   err,       1);
      chk({tag, "_valid"}, mem_valid, 0);
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_done"},  done,      0);
      tick();
      chk({tag, "_err_pulse"}, err, 0);
    end else begin
      chk({tag, "_busy"}, req_ready, 0);
      chk_beat({tag, "_b0"}, v.a0, v.s0, v.d0);
      tick();
      if (v.beats == 2'd2) begin
        chk_beat({tag, "_b1"}, v.a1, v.s1, v.d1);
        tick();
      end
      chk_idle_done({tag, "_end"});
      tick();
      chk({tag, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_1002, 32'hAABB_CCDD, 2'b00, 2'd1, 32'h0000_1000, 4'b0100, 32'h00DD_0000, 32'h0, 4'h0, 32'h0};
    vecs[1] = '{32'h0000_2001, 32'h1122_3344, 2'b10, 2'd2, 32'h0000_2000, 4'b1110, 32'h2233_4400, 32'h0000_2004, 4'b0001, 32'h0000_0011};
    vecs[2] = '{32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10, 2'd2, 32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000, 32'h0000_0000, 4'b0011, 32'h0000_CAFE};
    vecs[3] = '{32'h0000_3003, 32'h1234_BEEF, 2'b01, 2'd2, 32'h0000_3000, 4'b1000, 32'hEF00_0000, 32'h0000_3004, 4'b0001, 32'h0000_00BE};
    vecs[4] = '{32'h0000_5002, 32'hFFFF_8001, 2'b01, 2'd1, 32'h0000_5000, 4'b1100, 32'h8001_0000, 32'h0, 4'h0, 32'h0};
    vecs[5] = '{32'h0000_6000, 32'hDEAD_BEEF, 2'b10, 2'd1, 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0};
    vecs[6] = '{32'h0000_7003, 32'h0000_00A5, 2'b00, 2'd1, 32'h0000_7000, 4'b1000, 32'hA500_0000, 32'h0, 4'h0, 32'h0};
    vecs[7] = '{32'h0000_8000, 32'h1111_1111, 2'b11, 2'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[8] = '{32'h0000_9003, 32'h0102_0304, 2'b10, 2'd2, 32'h0000_9000, 4'b1000, 32'h0400_0000, 32'h0000_9004, 4'b0111, 32'h0001_0203};
    vecs[9] = '{32'h0000_A001, 32'h0000_C0DE, 2'b01, 2'd1, 32'h0000_A000, 4'b0110, 32'h00C0_DE00, 32'h0, 4'h0, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_valid_ns = 1'b0; mem_ready = 1'b1;
    req_addr = '0; req_data = '0; req_size = '0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strb",  mem_wstrb, 0);
    chk("rst_done",  done,      0);
    chk("rst_err",   err,       0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_store(vecs[i], $sformatf("v%0d", i));

    // Backpressure on an SH crossing store; a second request while busy is ignored.
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_3003; req_data = 32'h0000_BEEF; req_size = 2'b01;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_beat($sformatf("bp_hold%0d", c), 32'h0000_3000, 4'b1000, 32'hEF00_0000);
      chk($sformatf("bp_busy%0d", c), req_ready, 0);
      if (c == 0) begin
        req_valid = 1'b1; req_addr = 32'h0000_EEEE; req_size = 2'b00;
      end
      if (c == 1) req_valid = 1'b0;
      if (c < 2) tick();
    end
    mem_ready = 1'b1;
    tick();
    chk_beat("bp_b1", 32'h0000_3004, 4'b0001, 32'h0000_00BE);
    tick();
    chk_idle_done("bp_end");
    tick();
    chk("bp_done_pulse", done, 0);
    chk("bp_no_extra",   mem_valid, 0);

    // SPLIT_EN=0: crossing SW is rejected, aligned SW still completes.
    @(negedge clk);
    req_valid_ns = 1'b1; req_addr = 32'h0000_4002; req_data = 32'h5566_7788; req_size = 2'b10;
    tick();
    req_valid_ns = 1'b0;
    chk("ns_err",   err_ns,       1);
    chk("ns_valid", mem_valid_ns, 0);
    chk("ns_ready", req_ready_ns, 1);
    chk("ns_done",  done_ns,      0);
    tick();
    chk("ns_err_pulse", err_ns,       0);
    chk("ns_valid2",    mem_valid_ns, 0);
    @(negedge clk);
    req_valid_ns = 1'b1; req_addr = 32'h0000_4000;
    tick();
    req_valid_ns = 1'b0;
    chk("ns_ok_valid", mem_valid_ns, 1);
    chk("ns_ok_addr",  mem_addr_ns,  32'h0000_4000);
    chk("ns_ok_strb",  mem_wstrb_ns, 4'b1111);
    chk("ns_ok_wdata", mem_wdata_ns, 32'h5566_7788);
    tick();
    chk("ns_ok_done",  done_ns,      1);

    // Reset while beat 1 is stalled.
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_2001; req_data = 32'h1122_3344; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    chk_beat("rs_b0", 32'h0000_2000, 4'b1110, 32'h2233_4400);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_beat("rs_b1", 32'h0000_2004, 4'b0001, 32'h0000_0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", mem_valid, 0);
    chk("rs_addr",  mem_addr,  0);
    chk("rs_wdata", mem_wdata, 0);
    chk("rs_strb",  mem_wstrb, 0);
    chk("rs_done",  done,      0);
    chk("rs_err",   err,       0);
    chk("rs_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("rs_no_stray_done",  done,      0);
    chk("rs_no_stray_valid", mem_valid, 0);
    tick();
    chk("rs_no_stray_done2", done, 0);
    do_store(vecs[0], "rs_sb");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
